// File: rtl/polaris_pkg.sv
// Shared constants and types for the Polaris fetch path.
package polaris_pkg;

    // ADDI x0, x0, 0 -- the canonical RISC-V no-op.
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    // Byte address FFFF_FFFF_FFFF_FF00, stored as [63:2].
    localparam logic [61:0] RESET_PC_DEFAULT = 62'h3FFF_FFFF_FFFF_FFC0;

    // size_o encodings.
    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // External bus master states.
    typedef enum logic [1:0] {
        StIdle,
        StBeat,
        StDrain
    } bus_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {pc, insn}; flush beats push.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 94
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [WIDTH-1:0]             head_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_push = push_i & ~flush_i;

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= next_ptr(wr_q);
            if (pop_i)   rd_q <= next_ptr(rd_q);
            if (do_push && !pop_i)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && pop_i) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Entry storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_queue.sv
// Polaris instruction fetcher: multi-beat bus master feeding a prefetch queue into IR.
module fetch_queue
    import polaris_pkg::*;
#(
    parameter int unsigned BUS_W    = 16,
    parameter int unsigned DEPTH    = 2,
    parameter logic [61:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [BUS_W-1:0] dat_i,
    input  logic             ack_i,
    output logic [63:0]      adr_o,
    output logic [1:0]       size_o,
    output logic             vpa_o,
    input  logic [61:0]      csr_mtvec_i,
    input  logic             redirect_i,
    input  logic [61:0]      redirect_pc_i,
    input  logic             defined_i,
    input  logic             pause_i,
    output logic [31:0]      ir_o,
    output logic [61:0]      cpc_o,
    output logic             mpie_mie_o,
    output logic             mie_0_o,
    output logic             mcause_2_o,
    output logic             mepc_cpc_o
);

    localparam int unsigned BEATS     = 32 / BUS_W;
    localparam int unsigned CntW      = $clog2(DEPTH + 1);
    localparam logic [63:0] BeatBytes = 64'(BUS_W / 8);
    localparam logic [1:0]  BusSize   = (BUS_W == 16) ? SIZE_HALF : SIZE_WORD;

    bus_state_e        state_q, state_d;
    logic [61:0]       npc_q, npc_d;
    logic              beat_q, beat_d;
    logic [31:0]       asm_q, asm_d, asm_merge;
    logic [63:0]       hold_adr_q, hold_adr_d, beat_adr;
    logic [31:0]       ir_q, ir_d;
    logic [61:0]       cpc_q, cpc_d;

    logic              trap, flush, pop, push, last_beat, room_after;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic [93:0]       fifo_head;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (94)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (push),
        .pop_i    (pop),
        .flush_i  (flush),
        .data_i   ({npc_q, asm_merge}),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count),
        .head_o   (fifo_head)
    );

    // Trap beats redirect beats dispatch; a flush also suppresses the pop.
    always_comb begin
        trap      = ~defined_i & ~pause_i;
        flush     = trap | redirect_i;
        pop       = ~pause_i & defined_i & ~fifo_empty & ~flush;
        beat_adr  = {npc_q, 2'b00} + 64'(beat_q) * BeatBytes;
        last_beat = (32'(beat_q) == BEATS - 1);
        asm_merge = asm_q;
        asm_merge[32'(beat_q) * BUS_W +: BUS_W] = dat_i;
        // Occupancy after the push this cycle, net of a same-cycle pop.
        room_after = (pop ? 32'(fifo_count) : 32'(fifo_count) + 32'd1) < DEPTH;
    end

    // Bus FSM next state, beat sequencing and NPC update.
    always_comb begin
        state_d    = state_q;
        npc_d      = npc_q;
        beat_d     = beat_q;
        asm_d      = asm_q;
        hold_adr_d = hold_adr_q;
        push       = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_full && !flush) state_d = StBeat;
            end
            StBeat: begin
                if (ack_i) begin
                    asm_d = asm_merge;
                    if (flush) begin
                        state_d = StIdle;
                        beat_d  = 1'b0;
                    end else if (!last_beat) begin
                        beat_d = beat_q + 1'b1;
                    end else begin
                        push    = 1'b1;
                        npc_d   = npc_q + 62'd1;
                        beat_d  = 1'b0;
                        state_d = room_after ? StBeat : StIdle;
                    end
                end else if (flush) begin
                    // A beat cannot be aborted: freeze its address until ack.
                    state_d    = StDrain;
                    hold_adr_d = beat_adr;
                    beat_d     = 1'b0;
                end
            end
            StDrain: begin
                if (ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (trap)            npc_d = csr_mtvec_i;
        else if (redirect_i) npc_d = redirect_pc_i;
    end

    // IR / CPC next state.
    always_comb begin
        ir_d  = ir_q;
        cpc_d = cpc_q;
        if (trap) begin
            ir_d = NOP_INSN;
        end else if (pop) begin
            ir_d  = fifo_head[31:0];
            cpc_d = fifo_head[93:32];
        end
    end

    // Bus outputs decoded from the FSM state.
    always_comb begin
        adr_o  = '0;
        size_o = SIZE_NONE;
        vpa_o  = 1'b0;
        case (state_q)
            StBeat: begin
                adr_o  = beat_adr;
                size_o = BusSize;
                vpa_o  = 1'b1;
            end
            StDrain: begin
                adr_o  = hold_adr_q;
                size_o = BusSize;
                vpa_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // State registers; reset abandons any beat in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            npc_q      <= RESET_PC;
            beat_q     <= 1'b0;
            asm_q      <= '0;
            hold_adr_q <= '0;
            ir_q       <= NOP_INSN;
            cpc_q      <= RESET_PC;
        end else begin
            state_q    <= state_d;
            npc_q      <= npc_d;
            beat_q     <= beat_d;
            asm_q      <= asm_d;
            hold_adr_q <= hold_adr_d;
            ir_q       <= ir_d;
            cpc_q      <= cpc_d;
        end
    end

    assign ir_o       = ir_q;
    assign cpc_o      = cpc_q;
    assign mpie_mie_o = trap;
    assign mie_0_o    = trap;
    assign mcause_2_o = trap;
    assign mepc_cpc_o = trap;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a 16-bit and a 32-bit instance share stimulus.
module tb_fetch_queue;

    localparam logic [63:0] A_FF00 = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] NOP    = 64'h0000_0013;
    localparam logic [63:0] RPC    = 64'h3FFF_FFFF_FFFF_FFC0;

    logic        clk, reset_ni;
    logic [15:0] dat16;
    logic [31:0] dat32;
    logic        ack, defined, pause, redirect;
    logic [61:0] redirect_pc, mtvec;

    logic [63:0] adr16, adr32;
    logic [1:0]  size16, size32;
    logic        vpa16, vpa32;
    logic [31:0] ir16, ir32;
    logic [61:0] cpc16, cpc32;
    logic        mpie16, mie16, mcause16, mepc16;
    logic        mpie32, mie32, mcause32, mepc32;

    int n_vec = 0;
    int n_bad = 0;

    fetch_queue #(.BUS_W(16), .DEPTH(2)) dut16 (
        .clk_i(clk), .reset_ni(reset_ni), .dat_i(dat16), .ack_i(ack),
        .adr_o(adr16), .size_o(size16), .vpa_o(vpa16), .csr_mtvec_i(mtvec),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .defined_i(defined),
        .pause_i(pause), .ir_o(ir16), .cpc_o(cpc16), .mpie_mie_o(mpie16),
        .mie_0_o(mie16), .mcause_2_o(mcause16), .mepc_cpc_o(mepc16)
    );

    fetch_queue #(.BUS_W(32), .DEPTH(2)) dut32 (
        .clk_i(clk), .reset_ni(reset_ni), .dat_i(dat32), .ack_i(ack),
        .adr_o(adr32), .size_o(size32), .vpa_o(vpa32), .csr_mtvec_i(mtvec),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .defined_i(defined),
        .pause_i(pause), .ir_o(ir32), .cpc_o(cpc32), .mpie_mie_o(mpie32),
        .mie_0_o(mie32), .mcause_2_o(mcause32), .mepc_cpc_o(mepc32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: two fixed halfwords, otherwise data mirrors the address.
    always_comb begin
        case (adr16[15:0])
            16'hFF00: dat16 = 16'hAAAA;
            16'hFF02: dat16 = 16'hBBBB;
            default:  dat16 = adr16[15:0];
        endcase
        dat32 = {16'hC0DE, adr32[15:0]};
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Asserts reset away from a clock edge, checks the async reset state, leaves reset low.
    task automatic apply_reset();
        reset_ni    = 1'b0;
        ack         = 1'b1;
        defined     = 1'b1;
        pause       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mtvec       = '0;
        #1;
        check_val("rst_size16", 64'(size16), 64'd0);
        check_val("rst_vpa16", 64'(vpa16), 64'd0);
        check_val("rst_adr16", adr16, 64'd0);
        tick();
        tick();
        check_val("rst_ir16", 64'(ir16), NOP);
        check_val("rst_cpc16", 64'(cpc16), RPC);
        check_val("rst_mcause16", 64'(mcause16), 64'd0);
    endtask

    initial begin
        // 1: 16-bit bus, two beats per instruction.
        apply_reset();
        reset_ni = 1'b1;
        #1;
        check_val("t1_idle_size", 64'(size16), 64'd0);
        tick();
        check_val("t1_adr0", adr16, A_FF00);
        check_val("t1_size", 64'(size16), 64'h2);
        check_val("t1_vpa", 64'(vpa16), 64'd1);
        tick();
        check_val("t1_adr1", adr16, A_FF00 + 64'd2);
        tick();
        check_val("t1_adr2", adr16, A_FF00 + 64'd4);
        tick();
        check_val("t1_ir", 64'(ir16), 64'hBBBB_AAAA);
        check_val("t1_cpc", 64'(cpc16), RPC);
        check_val("t1_adr3", adr16, A_FF00 + 64'd6);

        // 2: 32-bit bus, one beat per instruction.
        apply_reset();
        reset_ni = 1'b1;
        tick();
        check_val("t2_adr0", adr32, A_FF00);
        check_val("t2_size", 64'(size32), 64'h3);
        check_val("t2_vpa", 64'(vpa32), 64'd1);
        tick();
        check_val("t2_adr1", adr32, A_FF00 + 64'd4);
        tick();
        check_val("t2_ir0", 64'(ir32), 64'hC0DE_FF00);
        check_val("t2_cpc0", 64'(cpc32), RPC);
        check_val("t2_adr2", adr32, A_FF00 + 64'd8);
        tick();
        check_val("t2_ir1", 64'(ir32), 64'hC0DE_FF04);
        check_val("t2_cpc1", 64'(cpc32), RPC + 64'd1);

        // 3: paused execute fills the 2-entry queue, then drains in order.
        apply_reset();
        pause    = 1'b1;
        reset_ni = 1'b1;
        tick();
        check_val("t3_adr0", adr16, A_FF00);
        tick();
        tick();
        check_val("t3_adr2", adr16, A_FF00 + 64'd4);
        tick();
        tick();
        check_val("t3_full_size", 64'(size16), 64'd0);
        check_val("t3_full_vpa", 64'(vpa16), 64'd0);
        check_val("t3_ir_held", 64'(ir16), NOP);
        tick();
        check_val("t3_still_idle", 64'(vpa16), 64'd0);
        pause = 1'b0;
        tick();
        check_val("t3_ir0", 64'(ir16), 64'hBBBB_AAAA);
        check_val("t3_cpc0", 64'(cpc16), RPC);
        tick();
        check_val("t3_ir1", 64'(ir16), 64'hFF06_FF04);
        check_val("t3_cpc1", 64'(cpc16), RPC + 64'd1);
        check_val("t3_resume", adr16, A_FF00 + 64'd8);

        // 4: redirect while a beat waits for ack; the beat drains, then fetch restarts.
        apply_reset();
        reset_ni = 1'b1;
        tick();
        tick();
        check_val("t4_adr1", adr16, A_FF00 + 64'd2);
        ack         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 62'h100;
        tick();
        redirect = 1'b0;
        check_val("t4_hold0", adr16, A_FF00 + 64'd2);
        check_val("t4_hold_vpa", 64'(vpa16), 64'd1);
        tick();
        check_val("t4_hold1", adr16, A_FF00 + 64'd2);
        tick();
        check_val("t4_hold2", adr16, A_FF00 + 64'd2);
        ack = 1'b1;
        tick();
        check_val("t4_idle", 64'(size16), 64'd0);
        check_val("t4_no_disp", 64'(ir16), NOP);
        tick();
        check_val("t4_new_adr", adr16, 64'h400);
        check_val("t4_ir", 64'(ir16), NOP);

        // 5: trap with a full queue; pulses last one cycle and the queue is dropped.
        apply_reset();
        pause    = 1'b1;
        reset_ni = 1'b1;
        repeat (5) tick();
        pause   = 1'b0;
        defined = 1'b0;
        mtvec   = 62'h1DDD_DDDD_DDDD_DDDD;
        #1;
        check_val("t5_mpie", 64'(mpie16), 64'd1);
        check_val("t5_mie0", 64'(mie16), 64'd1);
        check_val("t5_mcause", 64'(mcause16), 64'd1);
        check_val("t5_mepc", 64'(mepc16), 64'd1);
        check_val("t5_mcause32", 64'(mcause32), 64'd1);
        tick();
        defined = 1'b1;
        #1;
        check_val("t5_mpie_off", 64'(mpie16), 64'd0);
        check_val("t5_mie0_off", 64'(mie16), 64'd0);
        check_val("t5_mcause_off", 64'(mcause16), 64'd0);
        check_val("t5_mepc_off", 64'(mepc16), 64'd0);
        check_val("t5_mepc32_off", 64'(mepc32 | mie32 | mpie32), 64'd0);
        check_val("t5_ir_nop", 64'(ir16), NOP);
        tick();
        check_val("t5_vec_adr", adr16, 64'h7777_7777_7777_7774);
        check_val("t5_flushed0", 64'(ir16), NOP);
        tick();
        check_val("t5_flushed1", 64'(ir16), NOP);

        // 6: trap and redirect together -- the trap vector wins.
        apply_reset();
        reset_ni = 1'b1;
        tick();
        defined     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 62'h100;
        mtvec       = 62'h40;
        #1;
        check_val("t6_mcause", 64'(mcause16), 64'd1);
        tick();
        defined  = 1'b0 | 1'b1;
        redirect = 1'b0;
        tick();
        check_val("t6_adr", adr16, 64'h100);
        check_val("t6_vpa", 64'(vpa16), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Next-generation Polaris instruction fetcher with a parametrised external bus width and a prefetch queue of decoded-ready instructions.
- Fetches 32-bit RISC-V instructions in one or more bus beats and queues them with their PCs.
- Dispatches into IR when the execute unit is not pausing.
- Handles redirects from branches and jumps, and raises the illegal-instruction trap.
- Sits between the external bus master and the execute unit, replacing the single-slot fetcher.

Parameters:
- BUS_W, 16, data bus width in bits; legal values 16 and 32; beats per instruction BEATS = 32/BUS_W.
- DEPTH, 2, prefetch queue entries (1..8).
- RESET_PC, 62'h3FFF_FFFF_FFFF_FFC0, value of NPC[63:2] after reset (byte address FFFF_FFFF_FFFF_FF00).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- dat_i  in  BUS_W  bus read data.
- ack_i  in  1  bus beat acknowledge.
- adr_o  out  64  bus byte address.
- size_o  out  2  00 idle, 10 two bytes, 11 four bytes.
- vpa_o  out  1  opcode fetch in progress.
- csr_mtvec_i  in  62  trap vector [63:2].
- redirect_i  in  1  one-cycle pulse: new NPC from execute.
- redirect_pc_i  in  62  redirect target [63:2].
- defined_i  in  1  current ir_o is a legal instruction.
- pause_i  in  1  execute not ready to accept the next instruction.
- ir_o  out  32  instruction register.
- cpc_o  out  62  PC of ir_o [63:2].
- mpie_mie_o  out  1  trap pulse: copy MIE into MPIE.
- mie_0_o  out  1  trap pulse: clear MIE.
- mcause_2_o  out  1  trap pulse: MCAUSE = 2.
- mepc_cpc_o  out  1  trap pulse: MEPC <= cpc_o.

Behaviour:
- Reset (async, reset_ni low):
  - NPC = RESET_PC; queue empty; beat counter = 0; bus FSM = IDLE.
  - ir_o = 32'h00000013; cpc_o = RESET_PC.
  - size_o = 00, vpa_o = 0, adr_o = 0; all trap pulses 0.
  - Reset mid-beat abandons the beat immediately.
- Bus FSM states: IDLE, BEAT, DRAIN.
  - IDLE -> BEAT when queue count < DEPTH and no trap or redirect this cycle.
  - BEAT:
    - adr_o = {NPC,2'b00} + beat*(BUS_W/8); size_o = 10 if BUS_W=16, else 11; vpa_o = 1.
    - Signals are held stable until ack_i.
    - On ack_i, dat_i is captured into the assembly register slice [beat*BUS_W +: BUS_W].
    - If beat < BEATS-1: increment beat and stay in BEAT (back-to-back beats allowed).
    - On the final beat: push {NPC, assembled word}, NPC += 1, beat = 0.
    - After the final beat, go to BEAT again if the queue still has room after this push, else IDLE.
  - DRAIN is entered when a trap or redirect occurs while in BEAT without ack_i the same cycle.
    - The bus is held unchanged until ack_i; the data is discarded; no push; then IDLE.
    - A beat may not be aborted.
  - A trap or redirect coinciding with ack_i discards that beat and goes to IDLE directly.
- Dispatch, evaluated each cycle in priority order:
  - reset > trap > redirect > dispatch.
  - Trap (~defined_i & ~pause_i):
    - Assert mpie_mie_o, mie_0_o, mcause_2_o and mepc_cpc_o combinationally for exactly that cycle.
    - Flush the queue; NPC <= csr_mtvec_i; ir_o <= NOP.
  - Redirect (redirect_i): flush the queue; NPC <= redirect_pc_i; ir_o unchanged.
  - Dispatch (~pause_i & defined_i & queue non-empty): ir_o <= head instruction, cpc_o <= head PC, pop.
  - Queue empty and not paused: ir_o unchanged; retry next cycle.
- Queue behaviour:
  - Simultaneous push and pop is allowed; count is unchanged.
  - Push to a full queue cannot occur, because a fetch starts only when count < DEPTH.
  - The queue wraps its pointers modulo DEPTH.
- NPC arithmetic is modulo 2^62 (wraps from 3FFF...FFFF to 0).

Decomposition:
- Shared package polaris_pkg holds:
  - NOP_INSN = 32'h00000013.
  - RESET_PC_DEFAULT.
  - SIZE_NONE/SIZE_HALF/SIZE_WORD encodings.
  - The bus FSM state enum.
- One sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO of {pc[61:0], insn[31:0]}.
  - Ports: push, pop, flush, full, empty, head.
  - Flush has priority over push.

Test Plan:
1. Reset, BUS_W=16, then ack_i=1:
   - During reset: size_o=00, vpa_o=0, ir_o=00000013.
   - After release: adr_o = ...FF00 then ...FF02, dat AAAA/BBBB.
   - ir_o = BBBBAAAA, cpc_o = 3FFF_FFFF_FFFF_FFC0.
   - Next adr_o = ...FF04.
2. BUS_W=32, ack_i=1: one beat per instruction; adr_o = ...FF00 then ...FF04; size_o=11; ir_o equals dat_i word.
3. DEPTH=2, pause_i=1:
   - Two instructions fetched, then size_o=00 and vpa_o=0.
   - Drop pause_i: ir_o takes queued words in order and fetch resumes at ...FF08.
4. Redirect to 62'h100 in BEAT with ack_i=0 for 3 cycles:
   - adr_o held at ...FF02 until ack; data not dispatched.
   - Next adr_o = 0x400.
5. defined_i=0, pause_i=0:
   - The four trap pulses are high for exactly one cycle; queue flushed; ir_o=00000013.
   - Next adr_o = 7777777777777774 for mtvec 1DDD...DDD.
6. Trap and redirect_i in the same cycle: trap wins; next adr_o is from csr_mtvec_i, not redirect_pc_i.
